// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port arbiter in front of a single-ported, synchronous-read
// data RAM. Port 0 is the CPU data port, port 1 the DMA/device port, which may
// lock the RAM for up to MAX_LOCK consecutive cycles.
// Optional feature: define DM_ARBITER_RR_EN for round-robin arbitration of
// simultaneous requests in FREE. Without it, port 0 always wins.

// Per-port response stage: read valid, error pulse and zero-gated read data
module dm_arbiter_rsp (
  input  logic        clk,
  input  logic        reset,
  input  logic        gnt,
  input  logic        rd,
  input  logic        oor,
  input  logic [31:0] ram_rdata,
  output logic        rvalid,
  output logic        err,
  output logic [31:0] rdata
);
  // Track a granted read and any out-of-range access one cycle later
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid <= 1'b0;
      err    <= 1'b0;
    end else begin
      rvalid <= gnt & rd;
      err    <= gnt & oor;
    end
  end

  // Out-of-range reads return zero rather than whatever the RAM aliased to
  always_comb rdata = (rvalid && !err) ? ram_rdata : '0;
endmodule

module dm_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic [31:0]       m0_addr,
  input  logic [3:0]        m0_byteen,
  input  logic [31:0]       m0_wdata,
  input  logic              m1_req,
  input  logic [31:0]       m1_addr,
  input  logic [3:0]        m1_byteen,
  input  logic [31:0]       m1_wdata,
  input  logic              m1_lock,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [31:0]       m0_rdata,
  output logic [31:0]       m1_rdata,
  output logic              m0_err,
  output logic              m1_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_byteen,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);
  localparam int NP    = 2;
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
  } req_t;

  typedef enum logic {FREE, LOCKED1} st_t;

  req_t [NP-1:0]        req;
  req_t                 sel;
  logic [NP-1:0]        req_v, gnt, oor, rd, rvalid, err;
  logic [NP-1:0][31:0]  rdata;
  st_t                  st, st_nxt;
  logic [CNT_W-1:0]     cnt;
  logic                 prio0, hold_max, win1;

  assign req[0] = {m0_addr, m0_byteen, m0_wdata};
  assign req[1] = {m1_addr, m1_byteen, m1_wdata};
  assign req_v  = {m1_req, m0_req};

  for (genvar p = 0; p < NP; p++) begin : g_port
    assign oor[p] = |req[p].addr[31:ADDR_W+2];
    assign rd[p]  = (req[p].byteen == 4'b0000);
  end

  // This cycle would be port 1's MAX_LOCK-th consecutive held cycle
  assign hold_max = (cnt + CNT_W'(1)) == CNT_W'(MAX_LOCK);

`ifdef DM_ARBITER_RR_EN
  logic rr_pref;  // 1 = port 1 preferred on a tie

  // Prefer whichever port was not granted most recently
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      rr_pref <= 1'b0;
    else if (gnt[0]) rr_pref <= 1'b1;
    else if (gnt[1]) rr_pref <= 1'b0;
  end

  assign win1 = rr_pref & ~prio0;
`else
  assign win1 = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st <= FREE;
    else        st <= st_nxt;
  end

  // Next state: lock on a locked port-1 grant, release on lock drop or budget
  always_comb begin
    st_nxt = st;
    case (st)
      FREE:    if (gnt[1] && m1_lock) st_nxt = LOCKED1;
      LOCKED1: if (!m1_lock || hold_max) st_nxt = FREE;
      default: st_nxt = FREE;
    endcase
  end

  // Grant decode; held low throughout reset
  always_comb begin
    gnt = '0;
    if (reset) begin
      case (st)
        FREE:    gnt = (&req_v) ? (win1 ? 2'b10 : 2'b01) : req_v;
        LOCKED1: gnt[1] = m1_req;
        default: gnt = '0;
      endcase
    end
  end

  // Lock counter; after a budget release port 0 gets one cycle of priority
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      prio0 <= 1'b0;
    end else begin
      prio0 <= 1'b0;
      case (st)
        FREE: cnt <= (gnt[1] && m1_lock) ? CNT_W'(1) : '0;
        LOCKED1:
          if (!m1_lock) cnt <= '0;
          else if (hold_max) begin
            cnt   <= '0;
            prio0 <= 1'b1;
          end else cnt <= cnt + CNT_W'(1);
        default: cnt <= '0;
      endcase
    end
  end

  // RAM port follows the granted request; out-of-range or idle never writes
  always_comb begin
    sel        = gnt[1] ? req[1] : req[0];
    ram_addr   = sel.addr[ADDR_W+1:2];
    ram_wdata  = sel.wdata;
    ram_byteen = ((|gnt) && !(|(gnt & oor))) ? sel.byteen : 4'b0000;
  end

  dm_arbiter_rsp u_rsp [NP-1:0] (
    .clk       (clk),
    .reset     (reset),
    .gnt       (gnt),
    .rd        (rd),
    .oor       (oor),
    .ram_rdata (ram_rdata),
    .rvalid    (rvalid),
    .err       (err),
    .rdata     (rdata)
  );

  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];
  assign m0_rvalid = rvalid[0];
  assign m1_rvalid = rvalid[1];
  assign m0_err    = err[0];
  assign m1_err    = err[1];
  assign m0_rdata  = rdata[0];
  assign m1_rdata  = rdata[1];
endmodule

// File: tb/tb_dm_arbiter.sv
module tb_dm_arbiter;
  logic        clk = 1'b0, reset = 1'b0;
  logic        m0_req, m1_req, m1_lock;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_byteen, m1_byteen;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [11:0] ram_addr;
  logic [3:0]  ram_byteen;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic [31:0] mem [0:4095];
  int          n_chk = 0, n_pass = 0;
  logic        e0;

  dm_arbiter #(.ADDR_W(12), .MAX_LOCK(16)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_byteen(m0_byteen), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_byteen(m1_byteen), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .m0_err(m0_err), .m1_err(m1_err),
    .ram_addr(ram_addr), .ram_byteen(ram_byteen), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (ram_byteen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic drv0(input logic r, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    m0_req = r; m0_addr = a; m0_byteen = be; m0_wdata = wd;
  endtask

  task automatic drv1(input logic r, input logic [31:0] a, input logic [3:0] be, input logic lk);
    m1_req = r; m1_addr = a; m1_byteen = be; m1_wdata = 32'h11223344; m1_lock = lk;
  endtask

  initial begin
    drv0(0, 0, 0, 0); drv1(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    drv0(1, 32'h10, 4'hF, 32'h1); drv1(1, 32'h20, 4'h0, 1);
    #1;
    chk("rst_m0_gnt", m0_gnt, 1'b0);
    chk("rst_m1_gnt", m1_gnt, 1'b0);
    chk("rst_ram_byteen", ram_byteen, 4'h0);
    chk("rst_m0_rvalid", m0_rvalid, 1'b0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_m1_err", m1_err, 1'b0);
    drv0(0, 0, 0, 0); drv1(0, 0, 0, 0);
    reset = 1'b1;

    cyc(); drv0(1, 32'h10, 4'b0011, 32'hAABBCCDD); #1;
    chk("wr_gnt", m0_gnt, 1'b1);
    chk("wr_byteen", ram_byteen, 4'b0011);
    chk("wr_addr", ram_addr, 12'h004);
    chk("wr_wdata", ram_wdata, 32'hAABBCCDD);
    cyc(); drv0(1, 32'h10, 4'h0, 0); #1;
    chk("rd_gnt", m0_gnt, 1'b1);
    chk("rd_byteen", ram_byteen, 4'h0);
    chk("wr_no_rvalid", m0_rvalid, 1'b0);
    cyc(); drv0(0, 0, 0, 0); #1;
    chk("rd_rvalid", m0_rvalid, 1'b1);
    chk("rd_rdata", m0_rdata, 32'h0000CCDD);
    chk("rd_err", m0_err, 1'b0);

    drv1(1, 32'h10, 4'h0, 0); #1;
    chk("m1_gnt", m1_gnt, 1'b1);
    chk("m1_m0_gnt", m0_gnt, 1'b0);
    cyc(); drv1(0, 0, 0, 0); #1;
    chk("m1_rvalid", m1_rvalid, 1'b1);
    chk("m1_rdata", m1_rdata, 32'h0000CCDD);
    chk("m1_m0_rvalid", m0_rvalid, 1'b0);

    for (int i = 0; i < 4; i++) begin
      cyc(); drv0(1, 32'h20, 4'h0, 0); drv1(1, 32'h24, 4'h0, 0); #1;
`ifdef DM_ARBITER_RR_EN
      e0 = (i % 2 == 0);
`else
      e0 = 1'b1;
`endif
      chk("both_m0_gnt", m0_gnt, e0);
      chk("both_m1_gnt", m1_gnt, !e0);
    end

    cyc(); drv0(1, 32'h0001_0010, 4'hF, 32'hDEADBEEF); drv1(0, 0, 0, 0); #1;
    chk("oor_wr_gnt", m0_gnt, 1'b1);
    chk("oor_wr_byteen", ram_byteen, 4'h0);
    cyc(); drv0(1, 32'h0001_0010, 4'h0, 0); #1;
    chk("oor_wr_err", m0_err, 1'b1);
    chk("oor_wr_rvalid", m0_rvalid, 1'b0);
    cyc(); drv0(1, 32'h10, 4'h0, 0); #1;
    chk("oor_rd_rvalid", m0_rvalid, 1'b1);
    chk("oor_rd_err", m0_err, 1'b1);
    chk("oor_rd_rdata", m0_rdata, 32'h0);
    cyc(); drv0(0, 0, 0, 0); #1;
    chk("oor_no_corrupt", m0_rdata, 32'h0000CCDD);
    chk("oor_clear_err", m0_err, 1'b0);

    for (int i = 1; i <= 20; i++) begin
      cyc(); drv1(1, 32'h24, 4'h0, 1); drv0(i > 1, 32'h20, 4'h0, 0); #1;
      if (i <= 16) begin
        chk("lock_m1_gnt", m1_gnt, 1'b1);
        chk("lock_m0_gnt", m0_gnt, 1'b0);
      end else if (i == 17) begin
        chk("lock_rel_m0_gnt", m0_gnt, 1'b1);
        chk("lock_rel_m1_gnt", m1_gnt, 1'b0);
      end
    end
    cyc(); drv0(0, 0, 0, 0); drv1(0, 0, 0, 0);
    cyc();

    cyc(); drv1(1, 32'h24, 4'h0, 1); #1;
    chk("lk2_m1_gnt", m1_gnt, 1'b1);
    cyc(); drv1(0, 32'h24, 4'h0, 1); drv0(1, 32'h30, 4'hF, 32'h55); #1;
    chk("lk2_idle_m0", m0_gnt, 1'b0);
    chk("lk2_idle_m1", m1_gnt, 1'b0);
    chk("lk2_idle_be", ram_byteen, 4'h0);
    cyc(); drv1(0, 0, 0, 0); #1;
    chk("lk2_rel_m0", m0_gnt, 1'b0);
    cyc(); #1;
    chk("lk2_free_m0", m0_gnt, 1'b1);
    chk("lk2_free_be", ram_byteen, 4'hF);

    cyc(); drv0(0, 0, 0, 0); drv1(1, 32'h10, 4'h0, 1); #1;
    chk("rr_m1_gnt", m1_gnt, 1'b1);
    cyc(); #1;
    chk("rr_m1_gnt2", m1_gnt, 1'b1);
    chk("rr_m1_rvalid", m1_rvalid, 1'b1);
    reset = 1'b0; #1;
    chk("rr_async_gnt", m1_gnt, 1'b0);
    chk("rr_async_rvalid", m1_rvalid, 1'b0);
    chk("rr_async_rdata", m1_rdata, 32'h0);
    cyc();
    chk("rr_pending_rvalid", m1_rvalid, 1'b0);
    reset = 1'b1;
    drv1(0, 32'h10, 4'h0, 1); drv0(1, 32'h20, 4'h0, 0); #1;
    chk("rr_free_m0", m0_gnt, 1'b1);
    cyc(); #1;
    chk("rr_free_rvalid", m0_rvalid, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter ADDR_W, 12, word-address width of the shared data RAM (4096 words).
REQ-002 Parameter MAX_LOCK, 16, max consecutive cycles port 1 may hold a lock.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 m0_req/m1_req  input  1  access request, port 0 = CPU data port, port 1 = DMA/device port.
REQ-006 m0_addr/m1_addr  input  32  byte address; bits [1:0] ignored.
REQ-007 m0_byteen/m1_byteen  input  4  byte write enables; 4'b0000 means read.
REQ-008 m0_wdata/m1_wdata  input  32  write data, byte lanes per byteen.
REQ-009 m1_lock  input  1  port 1 requests to retain ownership on following cycles.
REQ-010 m0_gnt/m1_gnt  output  1  request accepted this cycle (combinational).
REQ-011 m0_rvalid/m1_rvalid  output  1  read data valid, one cycle after read grant.
REQ-012 m0_rdata/m1_rdata  output  32  read data; 0 when rvalid low.
REQ-013 m0_err/m1_err  output  1  pulses with rvalid/ack cycle when granted address out of range.
REQ-014 ram_addr  output  ADDR_W  word address = granted addr[ADDR_W+1:2].
REQ-015 ram_byteen  output  4  granted byteen; 0 when no write is issued.
REQ-016 ram_wdata  output  32  granted wdata.
REQ-017 ram_rdata  input  32  RAM read data, valid one cycle after ram_addr (synchronous read).

Function
REQ-018 At most one of m0_gnt/m1_gnt SHALL be high in any cycle; a grant is given only to a requesting port.
REQ-019 A grant SHALL drive the RAM port in the same cycle; a write completes at that clock edge.
REQ-020 For a granted read, the granted port's rvalid SHALL rise the next cycle with rdata = ram_rdata; writes produce no rvalid.
REQ-021 A granted access with addr[31:ADDR_W+2] nonzero SHALL force ram_byteen = 0 and pulse that port's err next cycle (with rvalid=1, rdata=0 if a read).
REQ-022 FSM states FREE and LOCKED1; reset state FREE.
REQ-023 FREE: with one requester, grant it; with both, arbitrate per REQ-030/031.
REQ-024 FREE -> LOCKED1 when m1 is granted with m1_lock=1; lock counter loads 1.
REQ-025 LOCKED1: m1 SHALL be granted whenever m1_req=1; m0 SHALL NOT be granted; counter increments per cycle.
REQ-026 LOCKED1 -> FREE when m1_lock=0, or counter reaches MAX_LOCK; on a MAX_LOCK release m0 gets priority next cycle if requesting.
REQ-027 LOCKED1 with m1_req=0 and m1_lock=1 SHALL leave the RAM idle (ram_byteen=0) and still count.
REQ-028 An rvalid pending when reset asserts SHALL be discarded.

Reset
REQ-029 While reset=0: state FREE, lock counter 0, round-robin pointer = port 0 preferred, all gnt/rvalid/err = 0, rdata = 0, ram_byteen = 0; takes effect without a clock edge.

Configuration
REQ-030 Macro DM_ARBITER_RR_EN defined: on simultaneous requests in FREE, grant the port not granted most recently (pointer updates on each grant).
REQ-031 Macro DM_ARBITER_RR_EN undefined: port 0 (CPU) always wins simultaneous requests in FREE; pointer logic absent; locking unchanged.

Verification
REQ-032 m0 write addr 0x10, byteen 4'b0011, wdata 0xAABBCCDD, then m0 read 0x10 on RAM preset 0 -> m0_gnt both cycles, read rvalid next cycle with rdata 0x0000CCDD.
REQ-033 Both ports read every cycle for 4 cycles, RR_EN defined -> grants alternate m0,m1,m0,m1; RR_EN undefined -> m0 all 4, m1 none.
REQ-034 m1 granted with m1_lock held high 20 cycles, m0 requesting throughout -> m1 owns 16 cycles, m0 granted on cycle 17, m0_gnt never high before.
REQ-035 m0 read addr 0x0001_0000 -> ram_byteen 0, next cycle m0_rvalid=1, m0_err=1, m0_rdata=0.
REQ-036 reset pulled low mid-read (between grant and rvalid) -> rvalid stays 0, outputs zero immediately, state FREE after release.
